// File: rtl/sar_search_if.sv
// Bundle between the search controller and its control/comparator side.
// The master drives start and the comparator result; the slave (the controller) drives the trial and the status.
interface sar_search_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [2:0]       cmp_o;
  logic [WIDTH-1:0] trial;
  logic             busy;
  logic             done;
  logic             found;
  logic             err;
  logic [WIDTH-1:0] result;

  modport master (
    output start, cmp_o,
    input  trial, busy, done, found, err, result
  );

  modport slave (
    input  start, cmp_o,
    output trial, busy, done, found, err, result
  );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation search controller for a WIDTH-bit magnitude comparator.
// Each trial goes out on comparator B. The one-hot {gt, eq, lt} result steers the trial MSB first.
//
//  state  | meaning
//  IDLE   | waiting for start; result, found and err held
//  SETTLE | registered trial has just changed; cmp_o ignored
//  SAMPLE | decode cmp_o, update trial or finish
//  DONE   | one-cycle done pulse, then back to IDLE
module sar_search #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  sar_search_if.slave  bus
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] trial, trial_nx;
  logic [WIDTH-1:0] result, result_nx;
  logic [IW-1:0]    idx, idx_nx;
  logic             verify, verify_nx;
  logic             found, found_nx;
  logic             err, err_nx;

  logic             cmp_gt, cmp_eq, cmp_lt, cmp_valid;
  logic [WIDTH-1:0] kept;
  logic [IW-1:0]    idx_dn;

  assign cmp_gt    = (bus.cmp_o == 3'b100);
  assign cmp_eq    = (bus.cmp_o == 3'b010);
  assign cmp_lt    = (bus.cmp_o == 3'b001);
  assign cmp_valid = cmp_gt | cmp_eq | cmp_lt;
  assign idx_dn    = idx - IW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      trial  <= '0;
      result <= '0;
      idx    <= '0;
      verify <= 1'b0;
      found  <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nx;
      trial  <= trial_nx;
      result <= result_nx;
      idx    <= idx_nx;
      verify <= verify_nx;
      found  <= found_nx;
      err    <= err_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    trial_nx  = trial;
    result_nx = result;
    idx_nx    = idx;
    verify_nx = verify;
    found_nx  = found;
    err_nx    = err;
    kept      = trial;

    case (state)
      IDLE: begin
        if (bus.start) begin
          trial_nx            = '0;
          trial_nx[WIDTH-1]   = 1'b1;
          idx_nx              = IW'(WIDTH - 1);
          verify_nx           = 1'b0;
          found_nx            = 1'b0;
          err_nx              = 1'b0;
          result_nx           = '0;
          state_nx            = SETTLE;
        end
      end

      SETTLE: begin
        state_nx = SAMPLE;
      end

      SAMPLE: begin
        if (!cmp_valid) begin
          err_nx    = 1'b1;
          found_nx  = 1'b0;
          result_nx = trial;
          state_nx  = DONE;
        end else if (verify) begin
          // Final check of the fully resolved word: anything but equal is a comparator fault.
          found_nx  = cmp_eq;
          err_nx    = ~cmp_eq;
          result_nx = trial;
          state_nx  = DONE;
        end else if (cmp_eq) begin
          found_nx  = 1'b1;
          result_nx = trial;
          state_nx  = DONE;
        end else begin
          kept[idx] = cmp_gt;
          if (idx != '0) begin
            kept[idx_dn] = 1'b1;
            idx_nx       = idx_dn;
          end else begin
            verify_nx = 1'b1;
          end
          trial_nx = kept;
          state_nx = SETTLE;
        end
      end

      DONE: begin
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.trial  = trial;
  assign bus.result = result;
  assign bus.found  = found;
  assign bus.err    = err;
  assign bus.busy   = (state == SETTLE) || (state == SAMPLE);
  assign bus.done   = (state == DONE);

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search: behavioural comparator against a target, hand-computed trials and latencies.
module tb_sar_search;

  logic       clk;
  logic       rst;
  logic [3:0] tgt;
  logic       force_en;
  logic [2:0] force_val;

  int n_chk;
  int n_err;
  int done_cyc;
  logic [3:0] tr_log [0:31];

  sar_search_if #(.WIDTH(4)) bus ();

  sar_search #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.cmp_o = force_en ? force_val
                              : {tgt > bus.trial, tgt == bus.trial, tgt < bus.trial};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Starts a search and records the trial seen in each cycle until done (bounded).
  task automatic search(input logic [3:0] t, input bit mid_start);
    tgt = t;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    done_cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mid_start) bus.start = (c == 3) || (c == 4);
      tr_log[c] = bus.trial;
      if (bus.done) begin
        done_cyc = c;
        break;
      end
    end
    bus.start = 1'b0;
  endtask

  initial begin
    n_chk     = 0;
    n_err     = 0;
    rst       = 1'b1;
    tgt       = 4'd0;
    force_en  = 1'b0;
    force_val = 3'b000;
    bus.start = 1'b0;

    #12;
    check("rst_trial",  int'(bus.trial),  0);
    check("rst_result", int'(bus.result), 0);
    check("rst_busy",   int'(bus.busy),   0);
    check("rst_done",   int'(bus.done),   0);
    check("rst_found",  int'(bus.found),  0);
    check("rst_err",    int'(bus.err),    0);
    @(negedge clk);
    rst = 1'b0;

    // 1: T=11, equal on the fourth trial
    search(4'd11, 1'b0);
    check("t11_tr1",    int'(tr_log[2]), 8);
    check("t11_tr2",    int'(tr_log[4]), 12);
    check("t11_tr3",    int'(tr_log[6]), 10);
    check("t11_tr4",    int'(tr_log[8]), 11);
    check("t11_cycle",  done_cyc, 9);
    check("t11_result", int'(bus.result), 11);
    check("t11_found",  int'(bus.found), 1);
    check("t11_err",    int'(bus.err), 0);
    @(negedge clk);
    check("t11_pulse",  int'(bus.done), 0);
    check("t11_hold",   int'(bus.result), 11);

    // 2: T=0, no early exit, verify trial
    search(4'd0, 1'b0);
    check("t0_tr1",    int'(tr_log[2]), 8);
    check("t0_tr2",    int'(tr_log[4]), 4);
    check("t0_tr3",    int'(tr_log[6]), 2);
    check("t0_tr4",    int'(tr_log[8]), 1);
    check("t0_verify", int'(tr_log[10]), 0);
    check("t0_cycle",  done_cyc, 11);
    check("t0_result", int'(bus.result), 0);
    check("t0_found",  int'(bus.found), 1);
    check("t0_err",    int'(bus.err), 0);

    // 3: T=8, first trial is equal
    search(4'd8, 1'b0);
    check("t8_cycle",  done_cyc, 3);
    check("t8_result", int'(bus.result), 8);
    check("t8_found",  int'(bus.found), 1);
    check("t8_busy",   int'(bus.busy), 0);

    // 4: invalid comparator codes
    force_en  = 1'b1;
    force_val = 3'b000;
    search(4'd3, 1'b0);
    check("inv000_cycle",  done_cyc, 3);
    check("inv000_err",    int'(bus.err), 1);
    check("inv000_found",  int'(bus.found), 0);
    check("inv000_result", int'(bus.result), 8);
    force_val = 3'b110;
    search(4'd3, 1'b0);
    check("inv110_cycle",  done_cyc, 3);
    check("inv110_err",    int'(bus.err), 1);
    check("inv110_found",  int'(bus.found), 0);
    check("inv110_result", int'(bus.result), 8);
    force_en = 1'b0;

    // 5: reset during the second SAMPLE of a T=5 search
    search(4'd13, 1'b0);
    check("t13_result", int'(bus.result), 13);
    tgt = 4'd5;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_trial", int'(bus.trial), 4);
    check("pre_rst_busy",  int'(bus.busy), 1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_trial",  int'(bus.trial), 0);
    check("rst_mid_busy",   int'(bus.busy), 0);
    check("rst_mid_result", int'(bus.result), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.done) check("rst_no_done", int'(bus.done), 0);
    end
    check("rst_idle_busy", int'(bus.busy), 0);

    search(4'd5, 1'b1);
    check("t5_tr1",    int'(tr_log[2]), 8);
    check("t5_tr2",    int'(tr_log[4]), 4);
    check("t5_tr3",    int'(tr_log[6]), 6);
    check("t5_tr4",    int'(tr_log[8]), 5);
    check("t5_cycle",  done_cyc, 9);
    check("t5_result", int'(bus.result), 5);
    check("t5_found",  int'(bus.found), 1);

    // 6: every target
    for (int t = 0; t < 16; t++) begin
      search(4'(t), 1'b0);
      check($sformatf("ex%0d_result", t), int'(bus.result), t);
      check($sformatf("ex%0d_found", t),  int'(bus.found), 1);
      check($sformatf("ex%0d_err", t),    int'(bus.err), 0);
      check($sformatf("ex%0d_cycle", t),  int'(done_cyc >= 3 && done_cyc <= 11), 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
